// File: rtl/timer_tick_scheduler.sv
// Four-channel software timer scheduler: each tick_in starts a scan that services one channel per cycle.
// Periodic auto-reload exists only when TIMER_SCHED_PERIODIC_EN is defined; otherwise channels are one-shot.
//
// state | meaning
// IDLE  | waiting for tick_in or a latched tick
// SCAN  | servicing channel idx, one per cycle, 0..3
module timer_tick_scheduler #(
  parameter int NUM_CH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [1:0]        idx;
  logic              tick_latched;
  logic [15:0]       count [NUM_CH];
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] mask;
  logic              overrun;
  logic [NUM_CH-1:0] periodic;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [15:0]       reload [NUM_CH];
`else
  assign periodic = '0;
`endif

  logic              wr;
  logic              host_hit;
  logic              step_do;
  logic              expire;
  logic [15:0]       cur_cnt;
  logic [15:0]       next_cnt;
  logic [NUM_CH-1:0] pend_set;
  logic [NUM_CH-1:0] pend_clr;
  logic              ovr_set;
  logic              ovr_clr;
  logic [1:0]        rd_ch;
  logic [15:0]       rd_mux;

  assign wr       = chipselect && !write_n;
  // COUNT/CTRL of channel ch live at address[3:1] == ch + 1
  assign host_hit = wr && (address[3:1] == ({1'b0, idx} + 3'd1));
  assign cur_cnt  = count[idx];
  assign step_do  = (state == SCAN) && enable[idx] && !host_hit;
  assign expire   = step_do && (cur_cnt <= 16'd1);
  // At index 3 the latched tick is consumed in the same cycle, so a new tick still fits
  assign ovr_set  = (state == SCAN) && tick_in && tick_latched && (idx != 2'd3);
  assign ovr_clr  = wr && (address == 4'd0) && writedata[4];
  assign pend_clr = (wr && (address == 4'd0)) ? writedata[NUM_CH-1:0] : '0;
  assign irq      = |(pending & mask);

  always_comb begin
    pend_set      = '0;
    pend_set[idx] = expire;
    next_cnt      = cur_cnt - 16'd1;
    if (expire) begin
`ifdef TIMER_SCHED_PERIODIC_EN
      next_cnt = periodic[idx] ? reload[idx] : 16'd0;
`else
      next_cnt = 16'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      tick_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_in || tick_latched) begin
            state        <= SCAN;
            idx          <= '0;
            tick_latched <= tick_in && tick_latched;
          end
        end
        SCAN: begin
          if (idx == 2'd3) begin
            idx          <= '0;
            tick_latched <= tick_in;
            if (!tick_latched) state <= IDLE;
          end else begin
            idx <= idx + 2'd1;
            if (tick_in) tick_latched <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      overrun <= 1'b0;
      mask    <= '0;
      enable  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        count[ch] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        reload[ch]   <= '0;
        periodic[ch] <= 1'b0;
`endif
      end
    end else begin
      // Set wins over a simultaneous write-1-to-clear
      pending <= (pending & ~pend_clr) | pend_set;
      overrun <= (overrun & ~ovr_clr) | ovr_set;
      if (wr && (address == 4'd1)) mask <= writedata[NUM_CH-1:0];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr && (address == 4'(2 + 2 * ch))) begin
          count[ch] <= writedata;
`ifdef TIMER_SCHED_PERIODIC_EN
          reload[ch] <= writedata;
`endif
        end else if (step_do && (idx == 2'(ch))) begin
          count[ch] <= next_cnt;
        end
        if (wr && (address == 4'(3 + 2 * ch))) begin
          enable[ch] <= writedata[0];
`ifdef TIMER_SCHED_PERIODIC_EN
          periodic[ch] <= writedata[1];
`endif
        end else if (expire && (idx == 2'(ch)) && !periodic[ch]) begin
          enable[ch] <= 1'b0;
        end
      end
    end
  end

  assign rd_ch = address[2:1] - 2'd1;

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0:                      rd_mux = {11'd0, overrun, pending};
      4'd1:                      rd_mux = {12'd0, mask};
      4'd2, 4'd4, 4'd6, 4'd8:    rd_mux = count[rd_ch];
      4'd3, 4'd5, 4'd7, 4'd9:    rd_mux = {14'd0, periodic[rd_ch], enable[rd_ch]};
      default:                   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end
endmodule

// File: doc/timer_tick_scheduler.md
TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of software timer channels; the only legal value is 4, which fixes the register map below.
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port tick_in, input, 1, a one-cycle timeout pulse from the interval timer.
REQ-005 The block SHALL have port address, input, 4, the register select.
REQ-006 The block SHALL have port chipselect, input, 1, the slave select.
REQ-007 The block SHALL have port write_n, input, 1, an active-low write strobe, qualified by chipselect.
REQ-008 The block SHALL have port writedata, input, 16, the write data.
REQ-009 The block SHALL have port readdata, output, 16, registered read data.
REQ-010 The block SHALL have port irq, output, 1, the combined interrupt request.

Function
REQ-011 The register map SHALL be:
- address 0: STATUS; bits [3:0] are pending flags, bit 4 is a sticky overrun flag; writing 1 to a bit clears it.
- address 1: MASK; bits [3:0] are the interrupt enables.
- address 2+2*ch: channel ch COUNT; a write loads both the reload value and the count, and a read returns the live count.
- address 3+2*ch: channel ch CTRL; bit 0 is enable, bit 1 is periodic.
- addresses 10 to 15 read 0 and ignore writes.
REQ-012 readdata SHALL present the selected register one cycle after the address is applied, on every cycle, independent of chipselect.
REQ-013 irq SHALL equal the OR over all channels of (pending[ch] AND mask[ch]), as combinational logic from registers.
REQ-014 The FSM SHALL have states IDLE and SCAN, with a 2-bit channel index.
REQ-015 In IDLE, a tick_in pulse, or a latched tick, SHALL move the FSM to SCAN with the index set to 0.
REQ-016 In SCAN, one channel SHALL be processed per cycle, at index 0, 1, 2 and then 3; after index 3 the FSM SHALL return to IDLE, or restart at index 0 if a tick is latched.
REQ-017 Processing a channel SHALL behave as follows:
- If the channel is disabled, nothing changes.
- If it is enabled and count > 1, count decrements by 1.
- If it is enabled and count is 1 or 0, the pending flag is set; in periodic mode count reloads to the reload value, otherwise count becomes 0 and enable clears.
REQ-018 A tick_in arriving while the FSM is in SCAN SHALL be latched in a one-deep tick latch.
REQ-019 A tick_in arriving while the tick latch is already full SHALL set the overrun flag, and that tick is dropped.
REQ-020 A host write to a channel's COUNT or CTRL register in the same cycle that channel is scanned SHALL take priority, and the scan step for that channel SHALL be skipped for that pass.
REQ-021 If a pending flag is set and cleared in the same cycle, it SHALL end up set; the same rule SHALL apply to the overrun flag.
REQ-022 Counts SHALL be 16-bit unsigned, decrementing SHALL never wrap below 0, and a reload value of 0 SHALL expire on every tick.

Reset
REQ-023 When reset is asserted, the following SHALL clear to 0 on the next clk edge: all counts, reload values, enables, periodic bits, pending flags, overrun, mask, the tick latch and readdata; irq SHALL read 0.
REQ-024 The FSM SHALL return to IDLE with the index at 0 on reset, including when reset is asserted mid-SCAN, and partial scan results SHALL be discarded.
REQ-025 tick_in and bus writes SHALL be ignored during any cycle in which reset is asserted.

Configuration
REQ-026 With macro TIMER_SCHED_PERIODIC_EN defined, CTRL bit 1 SHALL be writable and periodic auto-reload SHALL operate as specified in REQ-017.
REQ-027 Without TIMER_SCHED_PERIODIC_EN, CTRL bit 1 SHALL read 0 and ignore writes, all channels SHALL be one-shot only, and no storage SHALL be inferred for the periodic bits.

Verification
REQ-028 One-shot expiry: mask=0x1, COUNT0=3, CTRL0=0x1, then 3 ticks spaced 10 cycles apart -> irq rises within 5 cycles of the 3rd tick; STATUS reads 0x0001; CTRL0 reads 0; COUNT0 reads 0.
REQ-029 Periodic mode (macro defined): COUNT1=2, CTRL1=0x3, 4 ticks -> pending1 is set after the 2nd tick; a write of 0x0002 to STATUS clears it; it is set again after the 4th tick; COUNT1 reads 2.
REQ-030 Tick overrun: tick_in on 3 consecutive cycles -> the 2nd tick is latched and the 3rd sets STATUS bit 4; a write of 0x0010 clears it.
REQ-031 Write collision: a write of 0x0005 to COUNT2 in the exact cycle channel 2 is scanned -> COUNT2 reads 5, not 4.
REQ-032 Reset mid-SCAN: reset asserted at index 2 -> all registers read 0, irq=0, and the next tick begins a scan at index 0.
REQ-033 Set/clear race: a write of 0x0001 to STATUS in the cycle channel 0 expires -> pending0 remains 1.
